imem_loader: RTL and testbench

Instruction-memory writer and owner for the 4-bit CPU. Accepts 8-bit instruction bytes over a valid/ready stream and splits each into two nibbles: low nibble is the opcode, high nibble is the operand. Writes them into a 16x4 instruction memory at consecutive addresses. Holds the CPU in reset while loading, pulses wakeup when done, and serves the CPU's combinational two-nibble fetch port.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/imem_16x4.sv | 35 +++
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: loader FSM encoding, opcodes and
// default memory geometry.
package cpu_pkg;

  localparam int NIB_W_DEF  = 4;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WR_LO  = 3'd2,
    ST_WR_HI  = 3'd3,
    ST_FINISH = 3'd4
  } loader_state_e;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XNOR  = 4'b0111;
  localparam logic [3:0] OP_SLEEP = 4'b1000;

endpackage

// File: rtl/imem_16x4.sv
// Nibble-wide instruction memory: one synchronous write port and a combinational
// read of two consecutive nibbles (addr, addr+1 with wrap).
module imem_16x4
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NIB_W  = NIB_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [NIB_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [NIB_W-1:0]  rdata_lo_o,
  output logic [NIB_W-1:0]  rdata_hi_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [NIB_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] raddr_next;

  // NOTE: the array has no reset so program contents survive a loader reset
  // and the storage can map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign raddr_next = raddr_i + 1'b1;
  assign rdata_lo_o = mem_q[raddr_i];
  assign rdata_hi_o = mem_q[raddr_next];

endmodule

// File: rtl/imem_loader.sv
// Streams instruction bytes into the nibble memory, holds the CPU in reset
// while loading, pulses wakeup when the session ends, and serves CPU fetches.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NIB_W  = NIB_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*NIB_W-1:0]  in_data,
  input  logic                in_last,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [2*NIB_W-1:0]  rd_data,
  output logic                cpu_hold,
  output logic                wakeup,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   count,
  output logic                overflow
);

  localparam int MAX_INSTR = 2 ** (ADDR_W - 1);
  localparam logic [ADDR_W-1:0] MAX_CNT   = ADDR_W'(MAX_INSTR);
  localparam logic [ADDR_W-1:0] WPTR_STEP = ADDR_W'(2);

  loader_state_e       state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   count_inc;
  logic [2*NIB_W-1:0]  hold_q, hold_d;
  logic                hold_last_q, hold_last_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [NIB_W-1:0]    mem_wdata;
  logic [NIB_W-1:0]    rd_lo, rd_hi;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, matching real hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: every signal driven here gets a default first; any path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    count_inc   = count_q + 1'b1;
    mem_we      = 1'b0;
    mem_waddr   = wptr_q;
    mem_wdata   = hold_q[NIB_W-1:0];

    case (state_q)
      ST_IDLE: begin
        // Bytes offered while idle are dropped; only load_start matters here.
        if (load_start) begin
          wptr_d     = '0;
          count_d    = '0;
          done_d     = 1'b0;
          overflow_d = 1'b0;
          state_d    = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          hold_d      = in_data;
          hold_last_d = in_last;
          state_d     = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        mem_we  = 1'b1;
        state_d = ST_WR_HI;
      end
      ST_WR_HI: begin
        mem_we    = 1'b1;
        mem_waddr = wptr_q + 1'b1;
        mem_wdata = hold_q[2*NIB_W-1:NIB_W];
        wptr_d    = wptr_q + WPTR_STEP;
        count_d   = count_inc;
        if (hold_last_q || (count_inc == MAX_CNT)) begin
          overflow_d = ~hold_last_q;
          state_d    = ST_FINISH;
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  imem_16x4 #(
    .ADDR_W (ADDR_W),
    .NIB_W  (NIB_W)
  ) u_imem (
    .clk        (clk),
    .we_i       (mem_we),
    .waddr_i    (mem_waddr),
    .wdata_i    (mem_wdata),
    .raddr_i    (rd_addr),
    .rdata_lo_o (rd_lo),
    .rdata_hi_o (rd_hi)
  );

  assign rd_data  = {rd_hi, rd_lo};
  assign in_ready = (state_q == ST_ACCEPT);
  assign busy     = (state_q == ST_ACCEPT) || (state_q == ST_WR_LO) || (state_q == ST_WR_HI);
  assign cpu_hold = busy;
  assign wakeup   = (state_q == ST_FINISH);
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load sessions, backpressure, capacity end,
// ignored starts, mid-session reset and back-to-back sessions.
module tb_imem_loader;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic [3:0] rd_addr = 4'h0;
  logic [7:0] rd_data;
  logic       cpu_hold, wakeup, busy, done, overflow;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail = 0;
  int wakeup_cnt = 0;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cpu_hold   (cpu_hold),
    .wakeup     (wakeup),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wakeup === 1'b1) wakeup_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Offer one byte and hold it until accepted; returns at the WR_LO negedge.
  task automatic push_byte(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) break;
      tick();
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_timeout: in_ready=%b required 1 for byte %h", in_ready, d);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_wakeup(output int cyc, output int hold_low);
    cyc = -1;
    hold_low = 0;
    for (int i = 0; i < 16; i++) begin
      if (wakeup === 1'b1) begin
        cyc = i;
        break;
      end
      if (cpu_hold !== 1'b1) hold_low++;
      tick();
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, cpu_hold, wakeup, busy, done, overflow, count} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000000000",
               {in_ready, cpu_hold, wakeup, busy, done, overflow, count});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_checks++;
    if ({in_ready, busy, wakeup} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: ready/busy/wakeup=%b required 000", {in_ready, busy, wakeup});
    end
  endtask

  task automatic test_basic();
    int cyc, hl, w0;
    w0 = wakeup_cnt;
    pulse_start();
    n_checks++;
    if ({in_ready, busy, cpu_hold} !== 3'b111) begin
      n_fail++;
      $display("FAIL basic_accept: ready/busy/hold=%b required 111", {in_ready, busy, cpu_hold});
    end
    push_byte(8'h31, 1'b0);
    push_byte(8'h52, 1'b1);
    wait_wakeup(cyc, hl);
    n_checks++;
    if (cyc !== 2) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles required 2", cyc);
    end
    n_checks++;
    if (hl !== 0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: low-cycles=%0d hold_at_finish=%b required 0 and 0", hl, cpu_hold);
    end
    tick();
    n_checks++;
    if ({done, wakeup, count} !== {1'b1, 1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL basic_status: done=%b wakeup=%b count=%0d required 1 0 2", done, wakeup, count);
    end
    n_checks++;
    if (wakeup_cnt !== w0 + 1) begin
      n_fail++;
      $display("FAIL basic_wakeups: got %0d required %0d", wakeup_cnt - w0, 1);
    end
    rd_addr = 4'd0; #1;
    n_checks++;
    if (rd_data !== 8'h31) begin
      n_fail++;
      $display("FAIL basic_rd0: got %h required 31", rd_data);
    end
    rd_addr = 4'd1; #1;
    n_checks++;
    if (rd_data !== 8'h23) begin
      n_fail++;
      $display("FAIL basic_rd1: got %h required 23", rd_data);
    end
    rd_addr = 4'd2; #1;
    n_checks++;
    if (rd_data !== 8'h52) begin
      n_fail++;
      $display("FAIL basic_rd2: got %h required 52", rd_data);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes [3];
    bytes[0] = 8'h42; bytes[1] = 8'h75; bytes[2] = 8'h80;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = bytes[i];
      in_last  = (i == 2);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_ready_before_%0d: got %b required 1", i, in_ready);
      end
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_ready_low_%0d_%0d: got %b required 0", i, k, in_ready);
        end
        tick();
      end
      if (i < 2) begin
        tick();
        n_checks++;
        if ({in_ready, count} !== {1'b1, 4'(i + 1)}) begin
          n_fail++;
          $display("FAIL bp_gap_%0d: ready=%b count=%0d required 1 %0d", i, in_ready, count, i + 1);
        end
      end else begin
        n_checks++;
        if (wakeup !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_finish: wakeup=%b required 1", wakeup);
        end
      end
    end
    tick();
    n_checks++;
    if ({count, done, overflow} !== {4'd3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_status: count=%0d done=%b ovf=%b required 3 1 0", count, done, overflow);
    end
    rd_addr = 4'd2; #1;
    n_checks++;
    if (rd_data !== 8'h75) begin
      n_fail++;
      $display("FAIL bp_rd2: got %h required 75", rd_data);
    end
    rd_addr = 4'd4; #1;
    n_checks++;
    if (rd_data !== 8'h80) begin
      n_fail++;
      $display("FAIL bp_rd4: got %h required 80", rd_data);
    end
  endtask

  task automatic test_capacity();
    int cyc, hl;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      push_byte(8'h10 + 8'(i), 1'b0);
      if (i < 7) begin
        tick();
        tick();
      end
    end
    wait_wakeup(cyc, hl);
    n_checks++;
    if (cyc !== 2) begin
      n_fail++;
      $display("FAIL cap_latency: got %0d cycles required 2", cyc);
    end
    tick();
    n_checks++;
    if ({overflow, count, done} !== {1'b1, 4'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL cap_status: ovf=%b count=%0d done=%b required 1 8 1", overflow, count, done);
    end
    rd_addr = 4'd14; #1;
    n_checks++;
    if (rd_data !== 8'h17) begin
      n_fail++;
      $display("FAIL cap_rd14: got %h required 17", rd_data);
    end
    rd_addr = 4'd15; #1;
    n_checks++;
    if (rd_data !== 8'h01) begin
      n_fail++;
      $display("FAIL cap_rd15_wrap: got %h required 01", rd_data);
    end
  endtask

  task automatic test_ignored_starts();
    int cyc, hl;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({in_ready, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL ign_idle_%0d: ready/busy=%b required 00", i, {in_ready, busy});
      end
      tick();
    end
    n_checks++;
    if (count !== 4'd8) begin
      n_fail++;
      $display("FAIL ign_idle_count: got %0d required 8", count);
    end
    rd_addr = 4'd0; #1;
    n_checks++;
    if (rd_data !== 8'h10) begin
      n_fail++;
      $display("FAIL ign_idle_nowrite: got %h required 10", rd_data);
    end
    load_start = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, count, overflow, done} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ign_start: ready=%b count=%0d ovf=%b done=%b required 1 0 0 0",
               in_ready, count, overflow, done);
    end
    in_data = 8'h21;
    in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    load_start = 1'b0;
    tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n_checks++;
    if ({in_ready, busy, count} !== {1'b1, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL ign_mid: ready=%b busy=%b count=%0d required 1 1 1", in_ready, busy, count);
    end
    push_byte(8'h43, 1'b1);
    wait_wakeup(cyc, hl);
    tick();
    n_checks++;
    if ({count, overflow} !== {4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL ign_status: count=%0d ovf=%b required 2 0", count, overflow);
    end
    rd_addr = 4'd0; #1;
    n_checks++;
    if (rd_data !== 8'h21) begin
      n_fail++;
      $display("FAIL ign_rd0: got %h required 21", rd_data);
    end
    rd_addr = 4'd2; #1;
    n_checks++;
    if (rd_data !== 8'h43) begin
      n_fail++;
      $display("FAIL ign_rd2: got %h required 43", rd_data);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, hl, w0;
    pulse_start();
    push_byte(8'h65, 1'b0);
    tick();
    tick();
    push_byte(8'h9A, 1'b0);
    tick();
    w0 = wakeup_cnt;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, cpu_hold, wakeup, busy, done, overflow, count} !== 10'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b required 0000000000",
               {in_ready, cpu_hold, wakeup, busy, done, overflow, count});
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_checks++;
    if (wakeup_cnt !== w0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_nowake: wakeups=%0d busy=%b required 0 0", wakeup_cnt - w0, busy);
    end
    rd_addr = 4'd0; #1;
    n_checks++;
    if (rd_data !== 8'h65) begin
      n_fail++;
      $display("FAIL rstmid_rd0: got %h required 65", rd_data);
    end
    rd_addr = 4'd2; #1;
    n_checks++;
    if (rd_data !== 8'h4A) begin
      n_fail++;
      $display("FAIL rstmid_rd2_partial: got %h required 4a", rd_data);
    end
    pulse_start();
    push_byte(8'h07, 1'b1);
    wait_wakeup(cyc, hl);
    n_checks++;
    if (cyc !== 2) begin
      n_fail++;
      $display("FAIL rstmid_reload_latency: got %0d cycles required 2", cyc);
    end
    tick();
    rd_addr = 4'd0; #1;
    n_checks++;
    if ({rd_data, count} !== {8'h07, 4'd1}) begin
      n_fail++;
      $display("FAIL rstmid_reload: rd0=%h count=%0d required 07 1", rd_data, count);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, hl, w0;
    w0 = wakeup_cnt;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done_before: got %b required 1", done);
    end
    pulse_start();
    n_checks++;
    if ({done, count} !== {1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL b2b_start_clear: done=%b count=%0d required 0 0", done, count);
    end
    push_byte({4'h0, OP_SLEEP}, 1'b1);
    wait_wakeup(cyc, hl);
    n_checks++;
    if (cyc !== 2) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d cycles required 2", cyc);
    end
    tick();
    n_checks++;
    if ({count, overflow, done} !== {4'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_status: count=%0d ovf=%b done=%b required 1 0 1", count, overflow, done);
    end
    n_checks++;
    if (wakeup_cnt !== w0 + 1) begin
      n_fail++;
      $display("FAIL b2b_wakeups: got %0d required 1", wakeup_cnt - w0);
    end
    rd_addr = 4'd0; #1;
    n_checks++;
    if (rd_data !== 8'h08) begin
      n_fail++;
      $display("FAIL b2b_rd0: got %h required 08", rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_capacity();
    test_ignored_starts();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
